// File: rtl/decoder_scan_pkg.sv
// rtl/decoder_scan_pkg.sv - shared types, sizes and reset values for the decoder scan sequencer
package decoder_scan_pkg;

   localparam int NUM_CHAN = 8;
   localparam int CHAN_W   = 3;

`ifdef SCAN_GAP_EN
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DWELL = 2'd1,
      ST_GAP   = 2'd2
   } scan_state_e;
`else
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DWELL = 2'd1
   } scan_state_e;
`endif

   localparam logic [CHAN_W-1:0] RST_SEL  = '0;
   localparam logic              RST_EN   = 1'b0;
   localparam logic              RST_BUSY = 1'b0;
   localparam logic              RST_DONE = 1'b0;
   localparam logic              RST_WRAP = 1'b0;

   // Index of the lowest set bit; 0 for an empty mask.
   function automatic logic [CHAN_W-1:0] first_set(input logic [NUM_CHAN-1:0] mask);
      logic [CHAN_W-1:0] idx;
      idx = '0;
      for (int i = NUM_CHAN - 1; i >= 0; i--) begin
         if (mask[i]) idx = CHAN_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/decoder_scan_sequencer_next_chan.sv
// rtl/decoder_scan_sequencer_next_chan.sv - combinational next-channel lookup over the latched mask
module scan_next_chan
   import decoder_scan_pkg::*;
(
   input  logic [NUM_CHAN-1:0] mask_i,
   input  logic [CHAN_W-1:0]   cur_i,
   output logic [CHAN_W-1:0]   next_o,
   output logic                last_o,
   output logic [CHAN_W-1:0]   first_o
);

   always_comb begin
      first_o = first_set(mask_i);
      next_o  = first_o;
      last_o  = 1'b1;
      // Descending walk so the lowest set index above cur_i wins.
      for (int i = NUM_CHAN - 1; i >= 0; i--) begin
         if (mask_i[i] && (i > int'(cur_i))) begin
            next_o = CHAN_W'(i);
            last_o = 1'b0;
         end
      end
   end

endmodule

// File: rtl/decoder_scan_sequencer.sv
// rtl/decoder_scan_sequencer.sv - masked channel scan driving a 3-to-8 decoder's select/enable
// Optional SCAN_GAP_EN inserts a break-before-make GAP cycle between channels.
module decoder_scan_sequencer
   import decoder_scan_pkg::*;
#(
   parameter int DWELL_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                stop,
   input  logic                continuous,
   input  logic [NUM_CHAN-1:0] chan_mask,
   input  logic [DWELL_W-1:0]  dwell,
   output logic                A,
   output logic                B,
   output logic                C,
   output logic                en,
   output logic                busy,
   output logic                done,
   output logic                wrap
);

   scan_state_e          state_q, state_d;
   logic [CHAN_W-1:0]    sel_q, sel_d;
   logic                 en_q, en_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 wrap_q, wrap_d;
   logic [DWELL_W-1:0]   cnt_q, cnt_d;
   logic [DWELL_W-1:0]   dwell_q, dwell_d;
   logic [NUM_CHAN-1:0]  mask_q, mask_d;
   logic                 cont_q, cont_d;
`ifdef SCAN_GAP_EN
   logic                 gap_wrap_q, gap_wrap_d;
`endif

   logic [CHAN_W-1:0]    next_idx;
   logic [CHAN_W-1:0]    first_idx;
   logic                 last_chan;

   scan_next_chan u_next_chan (
      .mask_i  (mask_q),
      .cur_i   (sel_q),
      .next_o  (next_idx),
      .last_o  (last_chan),
      .first_o (first_idx)
   );

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      en_d    = en_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      wrap_d  = 1'b0;
      cnt_d   = cnt_q;
      dwell_d = dwell_q;
      mask_d  = mask_q;
      cont_d  = cont_q;
`ifdef SCAN_GAP_EN
      gap_wrap_d = gap_wrap_q;
`endif

      // Abort wins over start and over a coincident pass end; select is frozen.
      if (stop) begin
         state_d = ST_IDLE;
         en_d    = 1'b0;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start && (chan_mask != '0)) begin
                  state_d = ST_DWELL;
                  mask_d  = chan_mask;
                  dwell_d = dwell;
                  cont_d  = continuous;
                  sel_d   = first_set(chan_mask);
                  cnt_d   = '0;
                  en_d    = 1'b1;
                  busy_d  = 1'b1;
               end
            end
            ST_DWELL: begin
               if (cnt_q == dwell_q) begin
                  cnt_d = '0;
                  if (last_chan && !cont_q) begin
                     state_d = ST_IDLE;
                     en_d    = 1'b0;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end else begin
                     sel_d = last_chan ? first_idx : next_idx;
`ifdef SCAN_GAP_EN
                     state_d    = ST_GAP;
                     en_d       = 1'b0;
                     gap_wrap_d = last_chan;
`else
                     wrap_d = last_chan;
`endif
                  end
               end else begin
                  cnt_d = cnt_q + DWELL_W'(1);
               end
            end
`ifdef SCAN_GAP_EN
            ST_GAP: begin
               // Select already settled during the gap; enable the new channel now.
               state_d = ST_DWELL;
               en_d    = 1'b1;
               wrap_d  = gap_wrap_q;
            end
`endif
            default: begin
               state_d = ST_IDLE;
               en_d    = 1'b0;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sel_q   <= RST_SEL;
         en_q    <= RST_EN;
         busy_q  <= RST_BUSY;
         done_q  <= RST_DONE;
         wrap_q  <= RST_WRAP;
         cnt_q   <= '0;
         dwell_q <= '0;
         mask_q  <= '0;
         cont_q  <= 1'b0;
`ifdef SCAN_GAP_EN
         gap_wrap_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         wrap_q  <= wrap_d;
         cnt_q   <= cnt_d;
         dwell_q <= dwell_d;
         mask_q  <= mask_d;
         cont_q  <= cont_d;
`ifdef SCAN_GAP_EN
         gap_wrap_q <= gap_wrap_d;
`endif
      end
   end

   assign {A, B, C} = sel_q;
   assign en        = en_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign wrap      = wrap_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// tb/tb_decoder_scan_sequencer.sv - directed self-checking bench for decoder_scan_sequencer
module tb_decoder_scan_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       continuous = 1'b0;
   logic [7:0] chan_mask = 8'h00;
   logic [7:0] dwell = 8'h00;
   logic       A, B, C, en, busy, done, wrap;

   int checks = 0;
   int errors = 0;

   decoder_scan_sequencer #(.DWELL_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stop       (stop),
      .continuous (continuous),
      .chan_mask  (chan_mask),
      .dwell      (dwell),
      .A          (A),
      .B          (B),
      .C          (C),
      .en         (en),
      .busy       (busy),
      .done       (done),
      .wrap       (wrap)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Compares {sel,en,busy,done,wrap} against the expected tuple.
   task automatic chk_o(input string tag, input logic [2:0] s, input logic e,
                        input logic b, input logic d, input logic w);
      logic [6:0] obs;
      logic [6:0] exp;
      obs = {A, B, C, en, busy, done, wrap};
      exp = {s, e, b, d, w};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed sel/en/busy/done/wrap=%b expected %b", tag, obs, exp);
      end
   endtask

   logic [2:0] ss_ch [4];
   logic [2:0] gp_sel [7];
   logic       gp_en [7];
   logic       gp_wr [7];

   initial begin
      ss_ch = '{3'd0, 3'd2, 3'd5, 3'd7};

      #12;
      chk_o("reset_values", 3'd0, 0, 0, 0, 0);
      rst = 1'b0;
      step();

`ifndef SCAN_GAP_EN
      // start with an empty mask is ignored
      start = 1; chan_mask = 8'h00; dwell = 8'd3;
      step();
      chk_o("start_mask0", 3'd0, 0, 0, 0, 0);

      // start and stop together in IDLE
      stop = 1; chan_mask = 8'hA5;
      step();
      chk_o("start_stop_idle", 3'd0, 0, 0, 0, 0);
      stop = 0; start = 0;
      step();

      // single-shot A5, dwell 2
      start = 1; chan_mask = 8'hA5; dwell = 8'd2; continuous = 0;
      step();
      chk_o("ss_k0", ss_ch[0], 1, 1, 0, 0);
      start = 0;
      for (int k = 1; k < 12; k++) begin
         if (k == 4) begin
            start = 1; chan_mask = 8'hFF; dwell = 8'd0; continuous = 1;
         end
         step();
         if (k == 4) begin
            start = 0; continuous = 0;
         end
         chk_o($sformatf("ss_k%0d", k), ss_ch[k/3], 1, 1, 0, 0);
      end
      step();
      chk_o("ss_done", 3'd7, 0, 0, 1, 0);

      // back-to-back start right after done
      start = 1; chan_mask = 8'h01; dwell = 8'd0; continuous = 0;
      step();
      chk_o("b2b_start", 3'd0, 1, 1, 0, 0);
      start = 0;
      step();
      chk_o("b2b_done", 3'd0, 0, 0, 1, 0);
      step();
      chk_o("b2b_done_clear", 3'd0, 0, 0, 0, 0);

      // continuous 81, dwell 0
      start = 1; chan_mask = 8'h81; dwell = 8'd0; continuous = 1;
      step();
      chk_o("cont_e0", 3'd0, 1, 1, 0, 0);
      start = 0;
      step(); chk_o("cont_e1", 3'd7, 1, 1, 0, 0);
      step(); chk_o("cont_e2", 3'd0, 1, 1, 0, 1);
      step(); chk_o("cont_e3", 3'd7, 1, 1, 0, 0);
      step(); chk_o("cont_e4", 3'd0, 1, 1, 0, 1);
      stop = 1;
      step(); chk_o("cont_stop", 3'd0, 0, 0, 0, 0);
      stop = 0;
      step(); chk_o("cont_stop_idle", 3'd0, 0, 0, 0, 0);

      // single-bit continuous mask wraps every dwell+1 cycles
      start = 1; chan_mask = 8'h10; dwell = 8'd1; continuous = 1;
      step(); chk_o("one_e0", 3'd4, 1, 1, 0, 0);
      start = 0;
      step(); chk_o("one_e1", 3'd4, 1, 1, 0, 0);
      step(); chk_o("one_e2", 3'd4, 1, 1, 0, 1);
      step(); chk_o("one_e3", 3'd4, 1, 1, 0, 0);
      step(); chk_o("one_e4", 3'd4, 1, 1, 0, 1);
      stop = 1;
      step(); chk_o("one_stop", 3'd4, 0, 0, 0, 0);
      stop = 0;

      // stop coinciding with the single-shot pass end suppresses done
      start = 1; chan_mask = 8'h01; dwell = 8'd0; continuous = 0;
      step(); chk_o("stopend_e0", 3'd0, 1, 1, 0, 0);
      start = 0; stop = 1;
      step(); chk_o("stopend_e1", 3'd0, 0, 0, 0, 0);
      stop = 0;
      step(); chk_o("stopend_e2", 3'd0, 0, 0, 0, 0);
`else
      // gap mode: mask 03, dwell 1, continuous
      gp_sel = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0};
      gp_en  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      gp_wr  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      start = 1; chan_mask = 8'h03; dwell = 8'd1; continuous = 1;
      for (int k = 0; k < 7; k++) begin
         step();
         start = 0;
         chk_o($sformatf("gap_e%0d", k), gp_sel[k], gp_en[k], 1, 0, gp_wr[k]);
      end
      stop = 1;
      step(); chk_o("gap_stop", 3'd0, 0, 0, 0, 0);
      stop = 0;
`endif

      // asynchronous reset mid-scan
      start = 1; chan_mask = 8'hA4; dwell = 8'd5; continuous = 1;
      step();
      start = 0;
      step();
      chk_o("pre_rst", 3'd2, 1, 1, 0, 0);
      #2 rst = 1;
      #1 chk_o("async_rst", 3'd0, 0, 0, 0, 0);
      #2 rst = 0;
      step();
      chk_o("post_rst_idle", 3'd0, 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
